pow_n_pipe_rdy: RTL and testbench

Parametrised pipelined power unit. For each accepted argument it computes `arg^2 … arg^n` in w-bit modular arithmetic through an n-stage register pipeline. Handshakes are valid/ready on both sides, and the pipeline has a clock enable. Empty stages are collapsed, so bubbles are squeezed out under backpressure. It sits in the lab arithmetic datapath between a stimulus source (switches/counter) and a display or consumer that may stall.

---
 rtl/pow_pkg.sv | 19 +
 rtl/pow_stage.sv | 44 ++++
 rtl/pow_n_pipe_rdy.sv | 86 ++++++++
 tb/tb_pow_n_pipe_rdy.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_pkg.sv
// Shared constants and helpers for the pipelined power unit.
// Holds the truncating multiply used by every multiply stage.
package pow_pkg;

    localparam int POW_N_MIN = 2;
    localparam int POW_W_MAX = 64;

    // w-bit modular product; operands arrive zero-extended to 64 bits
    function automatic logic [63:0] pow_mul_trunc(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          width
    );
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (a * b) & mask;
    endfunction

endpackage

// File: rtl/pow_stage.sv
// One multiply stage: holds arg^1 .. arg^(s+1) for a single item.
// Loads when empty or when its own item moves on this cycle.
module pow_stage
    import pow_pkg::*;
#(
    parameter int w = 8,
    parameter int s = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 in_vld,
    input  logic [s*w-1:0]       in_pw,
    input  logic                 nxt_rdy,
    output logic                 vld,
    output logic                 rdy,
    output logic [(s+1)*w-1:0]   pw
);

    logic         adv;
    logic         load;
    logic [w-1:0] top_pw;

    assign adv    = vld & nxt_rdy;
    assign rdy    = !vld | adv;
    assign load   = clk_en & rdy;
    assign top_pw = w'(pow_mul_trunc(64'(in_pw[(s-1)*w +: w]),
                                     64'(in_pw[w-1:0]), w));

    // occupancy flag, cleared asynchronously so in-flight items vanish
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld <= 1'b0;
        else if (load)
            vld <= in_vld;
    end

    // new power on top, lower powers copied from the previous stage
    always_ff @(posedge clk) begin
        if (load)
            pw <= {top_pw, in_pw};
    end

endmodule

// File: rtl/pow_n_pipe_rdy.sv
// Pipelined power unit: arg^2 .. arg^n, w-bit modular, n stages.
// Ready ripples back from res_rdy so bubbles collapse under stall.
module pow_n_pipe_rdy
    import pow_pkg::*;
#(
    parameter int w = 8,
    parameter int n = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [w-1:0]         arg,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [(n-1)*w-1:0]   res
);

    // stage s occupies (s+1)*w bits starting at w*s*(s+1)/2
    localparam int TOT      = w * n * (n + 1) / 2;
    localparam int OFF_LAST = w * (n - 1) * n / 2;

    if (n < POW_N_MIN || w < 1 || w > POW_W_MAX) begin : g_bad_param
        $error("pow_n_pipe_rdy: illegal w/n");
    end

    logic [n-1:0]   vld;
    logic [n-1:0]   rdy;
    logic [n-1:0]   nxt_rdy;
    logic [TOT-1:0] pw;
    logic           vld0;
    logic [w-1:0]   p0;
    logic [w-1:0]   unused_arg1;

    assign vld[0]      = vld0;
    assign pw[w-1:0]   = p0;
    assign rdy[0]      = !vld0 | (vld0 & nxt_rdy[0]);
    assign arg_rdy     = clk_en & rdy[0];
    assign res_vld     = vld[n-1];
    assign res         = pw[OFF_LAST + w +: (n-1)*w];
    assign unused_arg1 = pw[OFF_LAST +: w];

    for (genvar i = 0; i < n; i++) begin : g_nxt
        if (i == n - 1) begin : g_last
            assign nxt_rdy[i] = res_rdy;
        end else begin : g_mid
            assign nxt_rdy[i] = rdy[i+1];
        end
    end

    // capture stage occupancy; arg_rdy already folds in clk_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld0 <= 1'b0;
        else if (arg_rdy)
            vld0 <= arg_vld;
    end

    // capture stage data, no reset needed
    always_ff @(posedge clk) begin
        if (arg_rdy)
            p0 <= arg;
    end

    for (genvar s = 1; s < n; s++) begin : g_stage
        localparam int OI = w * (s - 1) * s / 2;
        localparam int OO = w * s * (s + 1) / 2;

        pow_stage #(
            .w (w),
            .s (s)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clk_en  (clk_en),
            .in_vld  (vld[s-1]),
            .in_pw   (pw[OI +: s*w]),
            .nxt_rdy (nxt_rdy[s]),
            .vld     (vld[s]),
            .rdy     (rdy[s]),
            .pw      (pw[OO +: (s+1)*w])
        );
    end

endmodule

// File: tb/tb_pow_n_pipe_rdy.sv
// Directed bench for pow_n_pipe_rdy (w=8, n=5).
// Inputs change 1 unit after a rising edge; outputs sampled on falling edges.
module tb_pow_n_pipe_rdy;

    localparam int W = 8;
    localparam int N = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clk_en = 1'b1;
    logic               arg_vld = 1'b0;
    logic               arg_rdy;
    logic [W-1:0]       arg = '0;
    logic               res_vld;
    logic               res_rdy = 1'b1;
    logic [(N-1)*W-1:0] res;

    int n_assert = 0;
    int n_fail = 0;

    pow_n_pipe_rdy #(
        .w (W),
        .n (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .arg     (arg),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res)
    );

    always #5 clk = ~clk;

    // reference: {a^5, a^4, a^3, a^2}, each mod 256
    function automatic logic [31:0] pow_model(input logic [7:0] a);
        logic [7:0]  p;
        logic [31:0] r;
        p = a;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            p = p * a;
            r[k*8 +: 8] = p;
        end
        return r;
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_assert++;
        if (res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res_vld: got %b want 0", res_vld);
        end
        n_assert++;
        if (arg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_arg_rdy: got %b want 1", arg_rdy);
        end
        clk_en = 1'b0;
        #1;
        n_assert++;
        if (arg_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_arg_rdy_noen: got %b want 0", arg_rdy);
        end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_res_vld: got %b want 0", res_vld);
        end
    endtask

    task automatic test_single(input logic [7:0] a, input logic [31:0] exp);
        int lat;
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        arg = a;
        arg_vld = 1'b1;
        @(negedge clk);
        n_assert++;
        if (arg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_arg_rdy a=%0d: got %b want 1", a, arg_rdy);
        end
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (res_vld === 1'b1) begin
                lat = i;
                break;
            end
        end
        // first falling edge after the accepting edge counts as 1
        n_assert++;
        if (lat != N) begin
            n_fail++;
            $display("FAIL single_latency a=%0d: got %0d want %0d", a, lat, N);
        end
        n_assert++;
        if (res !== exp) begin
            n_fail++;
            $display("FAIL single_res a=%0d: got %h want %h", a, res, exp);
        end
        @(negedge clk);
        n_assert++;
        if (res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_one_cycle a=%0d: got %b want 0", a, res_vld);
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, drops, gaps, last_c;
        logic acc;
        sent = 0;
        got = 0;
        drops = 0;
        gaps = 0;
        last_c = 0;
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        arg_vld = 1'b1;
        arg = 8'd1;
        for (int c = 0; c < 60 && got < 20; c++) begin
            @(negedge clk);
            acc = arg_vld & arg_rdy;
            if (arg_vld && !arg_rdy)
                drops++;
            if (res_vld && res_rdy && clk_en) begin
                n_assert++;
                if (res !== pow_model(8'(got + 1))) begin
                    n_fail++;
                    $display("FAIL b2b_res #%0d: got %h want %h",
                             got, res, pow_model(8'(got + 1)));
                end
                if (got > 0 && c != last_c + 1)
                    gaps++;
                last_c = c;
                got++;
            end
            @(posedge clk);
            #1;
            if (acc)
                sent++;
            arg_vld = (sent < 20);
            arg = 8'(sent + 1);
        end
        arg_vld = 1'b0;
        n_assert++;
        if (got != 20) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 20", got);
        end
        n_assert++;
        if (drops != 0) begin
            n_fail++;
            $display("FAIL b2b_arg_rdy_drops: got %0d want 0", drops);
        end
        n_assert++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL b2b_gaps: got %0d want 0", gaps);
        end
    endtask

    task automatic test_stall();
        int sent, got, unstable;
        logic acc;
        sent = 0;
        got = 0;
        unstable = 0;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        arg_vld = 1'b1;
        arg = 8'd101;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = arg_vld & arg_rdy;
            if (res_vld && res !== pow_model(8'd101))
                unstable++;
            @(posedge clk);
            #1;
            if (acc)
                sent++;
            arg = 8'(101 + sent);
        end
        @(negedge clk);
        n_assert++;
        if (sent != N) begin
            n_fail++;
            $display("FAIL stall_accepted: got %0d want %0d", sent, N);
        end
        n_assert++;
        if (arg_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full_arg_rdy: got %b want 0", arg_rdy);
        end
        n_assert++;
        if (res_vld !== 1'b1 || unstable != 0) begin
            n_fail++;
            $display("FAIL stall_hold: res_vld %b unstable %0d want 1/0",
                     res_vld, unstable);
        end
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        for (int c = 0; c < 15 && got < 8; c++) begin
            @(negedge clk);
            if (res_vld && res_rdy && clk_en) begin
                n_assert++;
                if (res !== pow_model(8'(101 + got))) begin
                    n_fail++;
                    $display("FAIL stall_drain #%0d: got %h want %h",
                             got, res, pow_model(8'(101 + got)));
                end
                got++;
            end
        end
        n_assert++;
        if (got != N) begin
            n_fail++;
            $display("FAIL stall_drain_count: got %0d want %0d", got, N);
        end
    endtask

    task automatic test_bubble();
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        arg = 8'd7;
        arg_vld = 1'b1;
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        @(posedge clk);
        #1;
        arg = 8'd9;
        arg_vld = 1'b1;
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        n_assert++;
        if (res_vld !== 1'b1 || res !== pow_model(8'd7)) begin
            n_fail++;
            $display("FAIL bubble_head: vld %b res %h want 1/%h",
                     res_vld, res, pow_model(8'd7));
        end
        n_assert++;
        if (arg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bubble_arg_rdy: got %b want 1", arg_rdy);
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        // B must already sit right behind A, so it appears immediately
        @(negedge clk);
        n_assert++;
        if (res_vld !== 1'b1 || res !== pow_model(8'd9)) begin
            n_fail++;
            $display("FAIL bubble_collapse: vld %b res %h want 1/%h",
                     res_vld, res, pow_model(8'd9));
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_assert++;
        if (res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_empty: got %b want 0", res_vld);
        end
    endtask

    task automatic test_enable();
        int got;
        got = 0;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        arg_vld = 1'b1;
        arg = 8'd11;
        @(posedge clk);
        #1;
        arg = 8'd12;
        @(posedge clk);
        #1;
        arg = 8'd13;
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        clk_en = 1'b0;
        res_rdy = 1'b1;
        arg_vld = 1'b1;
        arg = 8'd99;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_assert++;
            if (arg_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL en_arg_rdy c=%0d: got %b want 0", c, arg_rdy);
            end
            n_assert++;
            if (res_vld !== 1'b1 || res !== pow_model(8'd11)) begin
                n_fail++;
                $display("FAIL en_hold c=%0d: vld %b res %h want 1/%h",
                         c, res_vld, res, pow_model(8'd11));
            end
        end
        @(posedge clk);
        #1;
        clk_en = 1'b1;
        arg_vld = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_vld && res_rdy && clk_en) begin
                n_assert++;
                if (res !== pow_model(8'(11 + got))) begin
                    n_fail++;
                    $display("FAIL en_drain #%0d: got %h want %h",
                             got, res, pow_model(8'(11 + got)));
                end
                got++;
            end
        end
        n_assert++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL en_drain_count: got %0d want 3", got);
        end
    endtask

    task automatic test_midreset();
        int stale, lat;
        stale = 0;
        lat = 0;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        arg_vld = 1'b1;
        arg = 8'd21;
        @(posedge clk);
        #1;
        arg = 8'd22;
        @(posedge clk);
        #1;
        arg = 8'd23;
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_assert++;
        if (res_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL mrst_pre_vld: got %b want 1", res_vld);
        end
        #2;
        rst = 1'b1;
        #1;
        n_assert++;
        if (res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_async_drop: got %b want 0", res_vld);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_vld !== 1'b0)
                stale++;
        end
        n_assert++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL mrst_stale: got %0d want 0", stale);
        end
        @(posedge clk);
        #1;
        arg = 8'd2;
        arg_vld = 1'b1;
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (res_vld === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_assert++;
        if (lat != N || res !== 32'h20100804) begin
            n_fail++;
            $display("FAIL mrst_fresh: lat %0d res %h want %0d/20100804",
                     lat, res, N);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(8'd3, 32'hF3511B09);
        test_single(8'd4, 32'h00004010);
        test_single(8'd255, 32'hFF01FF01);
        test_back_to_back();
        test_stall();
        test_bubble();
        test_enable();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
